// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and constants for the external bus controller.
//   state_t    : controller FSM states
//   PORT_CPU/PORT_DMA : requester port indices
//   BUS_W      : width of the multiplexed pad bus
//   hi_skip_ok : decides whether the ADDR_HI phase may be skipped
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    DATA    = 2'd3
  } state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;
  localparam int BUS_W    = 8;

  // The high-address latch still holds a valid byte equal to the new one.
  function automatic logic hi_skip_ok(input logic             en,
                                      input logic             hv,
                                      input logic [BUS_W-1:0] a_hi,
                                      input logic [BUS_W-1:0] held);
    return en && hv && (a_hi == held);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port round-robin arbiter.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_req0, i_req1   : request lines (port 0 = CPU, port 1 = DMA/debug)
//   i_take           : the grant is consumed this cycle (updates last_grant)
//   o_gnt_valid      : at least one request present
//   o_gnt_port       : index of the granted port
module rr_arbiter2
  import ext_bus_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_gnt_valid,
  output logic o_gnt_port
);

  logic r_last;
  logic w_port;

  // On a tie the port not served last wins; r_last resets to DMA so the
  // CPU wins the first tie.
  always_comb begin
    w_port = r_last;
    if (i_req0 && i_req1) w_port = ~r_last;
    else if (i_req0)      w_port = 1'(PORT_CPU);
    else if (i_req1)      w_port = 1'(PORT_DMA);
  end

  assign o_gnt_valid = i_req0 | i_req1;
  assign o_gnt_port  = w_port;

  always_ff @(posedge i_clk) begin
    if (i_rst)                          r_last <= 1'(PORT_DMA);
    else if (i_take && (i_req0 | i_req1)) r_last <= w_port;
  end

endmodule

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: arbitrates two requesters onto a multiplexed 8-bit external
// bus (address high byte, address low byte, data) with latch enables and
// active-low read/write strobes.
//   wb_clk_i, wb_rst_i            : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata      : request from port N (0 = CPU, 1 = DMA)
//   reqN_ack                      : transfer done on the edge valid&&ack
//   rdata                         : read data while an ack is high for a read
//   bus_in/bus_out/bus_oe         : pad input, pad output, pad drive enable
//   le_hi, le_lo, OEb, WEb        : address latch enables and strobes
//   busy                          : FSM not in IDLE
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int READ_WAIT = 0,
  parameter int HI_SKIP   = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [15:0]      req0_addr,
  input  logic [BUS_W-1:0] req0_wdata,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [15:0]      req1_addr,
  input  logic [BUS_W-1:0] req1_wdata,
  output logic             req0_ack,
  output logic             req1_ack,
  output logic [BUS_W-1:0] rdata,
  input  logic [BUS_W-1:0] bus_in,
  output logic [BUS_W-1:0] bus_out,
  output logic             bus_oe,
  output logic             le_hi,
  output logic             le_lo,
  output logic             OEb,
  output logic             WEb,
  output logic             busy
);

  localparam logic [1:0] LP_WAIT = 2'(READ_WAIT);

  state_t           r_state, w_next;
  logic             r_port;
  logic [15:0]      r_addr;
  logic             r_we;
  logic [BUS_W-1:0] r_wdata;
  logic [1:0]       r_cnt;
  logic             r_hi_valid;
  logic [BUS_W-1:0] r_hi_byte;

  logic             w_gnt_valid, w_gnt_port, w_idle;
  logic [15:0]      w_sel_addr, w_cur_addr;
  logic             w_sel_we, w_cur_we, w_cur_port;
  logic [BUS_W-1:0] w_sel_wdata, w_cur_wdata;
  logic             w_skip;
  logic [1:0]       w_cnt_nxt;

  logic             w_le_hi, w_le_lo, w_oeb, w_web, w_oe, w_ack0, w_ack1, w_data;
  logic [BUS_W-1:0] w_bus_out;

  assign w_idle = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_req0     (req0_valid),
    .i_req1     (req1_valid),
    .i_take     (w_idle),
    .o_gnt_valid(w_gnt_valid),
    .o_gnt_port (w_gnt_port)
  );

  assign w_sel_addr  = w_gnt_port ? req1_addr  : req0_addr;
  assign w_sel_we    = w_gnt_port ? req1_we    : req0_we;
  assign w_sel_wdata = w_gnt_port ? req1_wdata : req0_wdata;

  // Outputs are registered from the next state, so in the grant cycle the
  // decode must see the incoming request rather than the held copy.
  assign w_cur_addr  = w_idle ? w_sel_addr  : r_addr;
  assign w_cur_we    = w_idle ? w_sel_we    : r_we;
  assign w_cur_wdata = w_idle ? w_sel_wdata : r_wdata;
  assign w_cur_port  = w_idle ? w_gnt_port  : r_port;

  assign w_skip    = hi_skip_ok(HI_SKIP != 0, r_hi_valid, w_sel_addr[15:8], r_hi_byte);
  assign w_cnt_nxt = (r_state == DATA) ? (r_cnt + 2'd1) : 2'd0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt_valid) w_next = w_skip ? ADDR_LO : ADDR_HI;
      ADDR_HI: w_next = ADDR_LO;
      ADDR_LO: w_next = DATA;
      DATA:    if (r_cnt == LP_WAIT) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_le_hi   = (w_next == ADDR_HI);
    w_le_lo   = (w_next == ADDR_LO);
    w_data    = (w_next == DATA);
    w_oeb     = ~(w_data && !w_cur_we);
    w_web     = ~(w_data &&  w_cur_we);
    w_oe      = w_le_hi | w_le_lo | (w_data && w_cur_we);
    w_bus_out = '0;
    if (w_le_hi)                  w_bus_out = w_cur_addr[15:8];
    else if (w_le_lo)             w_bus_out = w_cur_addr[7:0];
    else if (w_data && w_cur_we)  w_bus_out = w_cur_wdata;
    // ack marks the final DATA cycle only
    w_ack0 = w_data && (w_cnt_nxt == LP_WAIT) && (w_cur_port == 1'(PORT_CPU));
    w_ack1 = w_data && (w_cnt_nxt == LP_WAIT) && (w_cur_port != 1'(PORT_CPU));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // ---- control registers and registered bus outputs ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_port     <= 1'b0;
      r_cnt      <= 2'd0;
      r_hi_valid <= 1'b0;
      le_hi      <= 1'b0;
      le_lo      <= 1'b0;
      OEb        <= 1'b1;
      WEb        <= 1'b1;
      bus_oe     <= 1'b0;
      bus_out    <= '0;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
    end else begin
      if (w_idle && w_gnt_valid) r_port <= w_gnt_port;
      if (r_state == ADDR_HI)    r_hi_valid <= 1'b1;
      r_cnt    <= w_cnt_nxt;
      le_hi    <= w_le_hi;
      le_lo    <= w_le_lo;
      OEb      <= w_oeb;
      WEb      <= w_web;
      bus_oe   <= w_oe;
      bus_out  <= w_bus_out;
      req0_ack <= w_ack0;
      req1_ack <= w_ack1;
    end
  end

  // ---- request capture (data path, no reset) ----
  always_ff @(posedge wb_clk_i) begin
    if (w_idle && w_gnt_valid) begin
      r_addr  <= w_sel_addr;
      r_we    <= w_sel_we;
      r_wdata <= w_sel_wdata;
    end
    if (r_state == ADDR_HI) r_hi_byte <= r_addr[15:8];
  end

  assign rdata = ((req0_ack | req1_ack) && !r_we) ? bus_in : '0;
  assign busy  = ~w_idle;

endmodule
